hazard_forward_ctrl: RTL and testbench

//  Produces the forward_decision selects consumed by the EX-stage operand forward muxes (A and B), plus pipeline stall/bubble

---
 rtl/hazard_forward_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-stage operand forwarding selects, load-use stall,
// multi-cycle EX hold and flush bubbles for a 5-stage pipeline. Keeps its own
// shadow copies of the instructions in EX, MEM and WB.
//
// Qualifier semantics: id_valid marks a real instruction in ID and is sampled
// every cycle; there is no ready. The core must hold IF/ID while stall_id=1
// and re-present the same ID instruction.
// ex_flush only takes effect when mc_busy=0. While mc_busy=1 the flush is
// dropped, not deferred.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              ex_flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic              mc_busy,
  output logic              mc_state_dbg
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
    logic              is_mc;
  } shadow_t;

  shadow_t   s_ex, s_mem, s_wb;
  shadow_t   ex_nx, mem_nx, wb_nx;
  mc_state_t state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic      lu;
  shadow_t   id_ins;

  // MEM/WB shadows are kept whole for debug visibility; only valid/rd/reg_write
  // feed the forwarding logic.
  logic      shadow_unused;
  assign shadow_unused = ^{s_mem, s_wb};

  assign id_ins = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, use1: id_use_rs1,
                    use2: id_use_rs2, rd: id_rd, reg_write: id_reg_write,
                    is_load: id_is_load, is_mc: id_is_mc};

  // The final occupancy cycle (counter at 0) releases the pipeline.
  assign mc_busy      = (state_q == MC_BUSY) && (cnt_q != '0);
  assign mc_state_dbg = state_q;

  function automatic logic match(input shadow_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
  endfunction

  // Forward selects for the instruction in EX; EX/MEM is newer than MEM/WB.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (s_ex.valid && s_ex.use1) begin
      if (match(s_mem, s_ex.rs1))     forward_a = 2'b10;
      else if (match(s_wb, s_ex.rs1)) forward_a = 2'b01;
    end
    if (s_ex.valid && s_ex.use2) begin
      if (match(s_mem, s_ex.rs2))     forward_b = 2'b10;
      else if (match(s_wb, s_ex.rs2)) forward_b = 2'b01;
    end
  end

  assign lu = id_valid && s_ex.valid && s_ex.is_load && (s_ex.rd != '0) &&
              ((id_use_rs1 && (id_rs1 == s_ex.rd)) || (id_use_rs2 && (id_rs2 == s_ex.rd)));

  // Control priority: multi-cycle hold, then flush, then load-use, then advance.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    state_nx   = MC_IDLE;
    cnt_nx     = '0;
    ex_nx      = s_ex;
    mem_nx     = s_ex;
    wb_nx      = s_mem;
    if (mc_busy) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      bubble_mem = 1'b1;
      mem_nx     = '0;
      state_nx   = MC_BUSY;
      cnt_nx     = cnt_q - CW'(1);
    end else if (ex_flush) begin
      bubble_ex = 1'b1;
      ex_nx     = '0;
    end else if (lu) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      ex_nx     = '0;
    end else begin
      ex_nx = id_ins;
      // Busy starts the cycle the op lands in EX, so it counts as cycle 1.
      if (id_valid && id_is_mc) begin
        state_nx = MC_BUSY;
        cnt_nx   = CW'(MC_LAT - 1);
      end
    end
  end

  // Shadow pipeline and multi-cycle state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ex    <= '0;
      s_mem   <= '0;
      s_wb    <= '0;
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      s_ex    <= ex_nx;
      s_mem   <= mem_nx;
      s_wb    <= wb_nx;
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed program fragments plus random instruction
// streams, checked each cycle against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;

  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, id_is_mc, ex_flush;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]        forward_a, forward_b;
  logic              stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, mc_busy, mc_state_dbg;

  hazard_forward_ctrl #(.REG_AW(REG_AW), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .ex_flush(ex_flush), .forward_a(forward_a), .forward_b(forward_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .mc_busy(mc_busy),
    .mc_state_dbg(mc_state_dbg)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit valid; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit ld; bit mc;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_age;   // cycles the instruction in EX has spent there so far
  ins_t nop;

  function automatic ins_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit ld, bit mc);
    ins_t i;
    i.valid = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
    i.rw = rw; i.ld = ld; i.mc = mc;
    return i;
  endfunction

  function automatic bit writes(ins_t s, int r);
    return s.valid && s.rw && s.rd != 0 && s.rd == r;
  endfunction

  function automatic logic [1:0] sel(bit use_it, int r);
    if (!m_ex.valid || !use_it) return 2'b00;
    if (writes(m_mem, r)) return 2'b10;
    if (writes(m_wb, r))  return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    return m_ex.valid && m_ex.mc && m_age < MC_LAT;
  endfunction

  function automatic bit m_lu(ins_t id);
    return id.valid && m_ex.valid && m_ex.ld && m_ex.rd != 0 &&
           ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
  endfunction

  // {forward_a, forward_b, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, mc_busy}
  function automatic logic [9:0] model_out(ins_t id, bit fl);
    logic [9:0] o;
    o = {sel(m_ex.u1, m_ex.rs1), sel(m_ex.u2, m_ex.rs2), 6'b0};
    if (m_busy())    o[5:0] = 6'b111011;
    else if (fl)     o[5:0] = 6'b000100;
    else if (m_lu(id)) o[5:0] = 6'b110100;
    return o;
  endfunction

  task automatic model_step(ins_t id, bit fl, bit rstn);
    bit busy, lu;
    busy = m_busy();
    lu   = m_lu(id);
    if (!rstn) begin
      m_ex = nop; m_mem = nop; m_wb = nop; m_age = 0;
    end else if (busy) begin
      m_age++;
      m_wb  = m_mem;
      m_mem = nop;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (fl || lu) ? nop : id;
      m_age = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [9:0] e, g;
        e = exp_q.pop_front();
        g = {forward_a, forward_b, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, mc_busy};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got fa=%b fb=%b sif=%b sid=%b sex=%b bex=%b bmem=%b busy=%b expected fa=%b fb=%b sif=%b sid=%b sex=%b bex=%b bmem=%b busy=%b",
                   $time, g[9:8], g[7:6], g[5], g[4], g[3], g[2], g[1], g[0],
                   e[9:8], e[7:6], e[5], e[4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(ins_t id, bit fl, bit rstn);
    id_valid     = id.valid;
    id_rs1       = REG_AW'(id.rs1);
    id_rs2       = REG_AW'(id.rs2);
    id_use_rs1   = id.u1;
    id_use_rs2   = id.u2;
    id_rd        = REG_AW'(id.rd);
    id_reg_write = id.rw;
    id_is_load   = id.ld;
    id_is_mc     = id.mc;
    ex_flush     = fl;
    rst_n        = rstn;
  endtask

  // One pipeline cycle: drive, predict, clock, advance the model.
  task automatic cycle(ins_t id, bit fl, bit rstn, output bit held);
    logic [9:0] e;
    drive(id, fl, rstn);
    e = model_out(id, fl);
    held = e[4];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    model_step(id, fl, rstn);
  endtask

  ins_t prog[$];
  bit   prog_fl[$];

  task automatic add(ins_t i, bit fl);
    prog.push_back(i);
    prog_fl.push_back(fl);
  endtask

  // Feed the program through ID, re-presenting an instruction while ID is held.
  task automatic run_prog(bit rand_rst);
    int idx = 0;
    int budget = 0;
    bit first = 1;
    bit held;
    bit rstn;
    while (idx < prog.size() && budget < 20000) begin
      rstn = rand_rst ? ($urandom_range(0, 149) != 0) : 1'b1;
      cycle(prog[idx], first ? prog_fl[idx] : 1'b0, rstn, held);
      budget++;
      if (held && rstn) first = 0;
      else begin idx++; first = 1; end
    end
    checks++;
    if (idx < prog.size()) begin
      errors++;
      $display("FAIL prog_budget issued=%0d required=%0d", idx, prog.size());
    end
    prog.delete();
    prog_fl.delete();
  endtask

  function automatic ins_t rnd_ins();
    ins_t i;
    i.valid = ($urandom_range(0, 9) != 0);
    i.rd  = $urandom_range(0, 3);
    i.rs1 = $urandom_range(0, 3);
    i.rs2 = $urandom_range(0, 3);
    i.u1  = ($urandom_range(0, 4) != 0);
    i.u2  = ($urandom_range(0, 4) != 0);
    i.rw  = ($urandom_range(0, 6) != 0);
    i.ld  = ($urandom_range(0, 3) == 0);
    i.mc  = !i.ld && ($urandom_range(0, 11) == 0);
    return i;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit h;
    nop = '{default: 0};
    drive(nop, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_step(nop, 0, 0);

    // reset state, then forwarding from EX/MEM and MEM/WB
    add(nop, 0);
    add(mk(5, 1, 2, 1, 1, 1, 0, 0), 0);
    add(mk(6, 5, 1, 1, 1, 1, 0, 0), 0);
    add(mk(9, 5, 3, 1, 1, 1, 0, 0), 0);
    add(nop, 0); add(nop, 0);
    // x5 in both MEM and WB; x0 writer never forwards
    add(mk(5, 1, 1, 1, 1, 1, 0, 0), 0);
    add(mk(5, 2, 2, 1, 1, 1, 0, 0), 0);
    add(mk(9, 5, 5, 1, 1, 1, 0, 0), 0);
    add(mk(0, 1, 1, 1, 1, 1, 0, 0), 0);
    add(mk(8, 0, 0, 1, 1, 1, 0, 0), 0);
    // load-use: one stall then MEM/WB forwarding
    add(mk(7, 1, 1, 1, 1, 1, 1, 0), 0);
    add(mk(8, 7, 7, 1, 1, 1, 0, 0), 0);
    add(nop, 0); add(nop, 0);
    // multi-cycle op, dependent reader waits in ID
    add(mk(10, 1, 2, 1, 1, 1, 0, 1), 0);
    add(mk(11, 10, 10, 1, 1, 1, 0, 0), 1);
    add(nop, 0); add(nop, 0);
    // flush and load-use in the same cycle
    add(mk(7, 1, 1, 1, 1, 1, 1, 0), 0);
    add(mk(8, 7, 1, 1, 1, 1, 0, 0), 1);
    add(mk(3, 7, 7, 1, 1, 1, 0, 0), 0);
    add(nop, 0);
    run_prog(0);

    // reset on busy cycle 2
    cycle(mk(10, 1, 2, 1, 1, 1, 0, 1), 0, 1, h);
    cycle(mk(11, 10, 1, 1, 1, 1, 0, 0), 0, 1, h);
    cycle(mk(11, 10, 1, 1, 1, 1, 0, 0), 0, 0, h);
    cycle(nop, 0, 1, h);
    cycle(nop, 0, 1, h);

    // random streams
    for (int n = 0; n < 1500; n++) add(rnd_ins(), $urandom_range(0, 14) == 0);
    run_prog(1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
